cache_refill_ctrl: RTL

//  Miss handler directly downstream of the direct-mapped data cache in the M stage.
//  On a load miss it stalls the pipeline and fetches the word from data memory over a
//  req/ready handshake. It then drives the cache refill port (EN, address, data) for one

---
 rtl/cache_refill_ctrl_pkg.sv | 20 ++
 rtl/cache_refill_ctrl_sat_counter.sv | 30 +++
 rtl/cache_refill_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types for the M-stage data-cache miss handler.
// Refill FSM states, cache opcodes and default timeout.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FILL
  } refill_state_e;

  localparam logic [2:0] WE_LW  = 3'b000;
  localparam logic [2:0] WE_LB  = 3'b010;
  localparam logic [2:0] WE_LBU = 3'b110;
  localparam logic [2:0] WE_SW  = 3'b001;
  localparam logic [2:0] WE_SB  = 3'b011;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/cache_refill_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async high), inc_i, clr_i, cnt_o[W].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Load-miss handler: stalls, fetches a word, refills cache.
// Ports: access/op/addr/hit in, mem req/ready, refill, stall, err, perf count.
module cache_refill_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              access_valid_i,
  input  logic [2:0]        WE_i,
  input  logic [ADDR_W-1:0] A_i,
  input  logic              cache_hit_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              refill_en_o,
  output logic [ADDR_W-1:0] refill_addr_o,
  output logic [DATA_W-1:0] refill_data_o,
  output logic              stall_o,
  output logic              err_o,
  output logic [PERF_W-1:0] miss_cnt_o
);

  // last WAIT cycle index before abort
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  refill_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              err_q, err_d;

  logic load, miss, inc;

  // only WE_i[0] separates loads from stores; byte lane is cache's job
  logic unused_bits;
  assign unused_bits = ^{WE_i[2:1], A_i[1:0]};

  assign load = access_valid_i && !WE_i[0];
  assign miss = load && !cache_hit_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    inc         = 1'b0;
    mem_req_o   = 1'b0;
    refill_en_o = 1'b0;
    stall_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o = miss && !rst;
        if (miss) begin
          addr_d  = {A_i[ADDR_W-1:2], 2'b00};
          inc     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        wcnt_d    = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        // ready wins over a simultaneous timeout
        if (mem_ready_i) begin
          data_d  = mem_rdata_i;
          state_d = FILL;
        end else if (wcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      FILL: begin
        refill_en_o = 1'b1;
        stall_o     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .W(PERF_W)
  ) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(inc),
    .clr_i(1'b0),
    .cnt_o(miss_cnt_o)
  );

  assign mem_addr_o    = addr_q;
  assign refill_addr_o = addr_q;
  assign refill_data_o = data_q;
  assign err_o         = err_q;

endmodule
